// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared definitions for the LCD_CTRL host driver.
//                Holds the command codes, the readback image size and the
//                host FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // LCD_CTRL command codes. The host passes them through without decoding,
    // except that CMD_WRITE ends the script phase and starts the readback.
    localparam logic [3:0] CMD_WRITE   = 4'h0;
    localparam logic [3:0] CMD_SHIFT_U = 4'h1;
    localparam logic [3:0] CMD_SHIFT_D = 4'h2;
    localparam logic [3:0] CMD_SHIFT_L = 4'h3;
    localparam logic [3:0] CMD_SHIFT_R = 4'h4;
    localparam logic [3:0] CMD_MAX     = 4'h5;
    localparam logic [3:0] CMD_MIN     = 4'h6;
    localparam logic [3:0] CMD_AVG     = 4'h7;
    localparam logic [3:0] CMD_CCW     = 4'h8;
    localparam logic [3:0] CMD_CW      = 4'h9;
    localparam logic [3:0] CMD_MIRX    = 4'hA;
    localparam logic [3:0] CMD_MIRY    = 4'hB;

    // Pixels in the IRB image (8x8).
    localparam int IMG_N = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_ACK       = 3'd2,
        ST_EXEC      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RD        = 3'd5,
        ST_DRAIN     = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_cmd_host_if
//  Description : Bus between the host driver and LCD_CTRL / its IRB memory.
//                master = host (issues commands, reads IRB)
//                slave  = LCD_CTRL side (busy/done, IRB read data)
//    cmd[3:0]   command to LCD_CTRL          (master -> slave)
//    cmd_valid  1-cycle command strobe       (master -> slave)
//    busy       LCD_CTRL executing           (slave  -> master)
//    done       Write phase finished         (slave  -> master)
//    rb_cen     IRB read enable, active-low  (master -> slave)
//    rb_a[5:0]  IRB read address             (master -> slave)
//    rb_q[7:0]  IRB data, one cycle later    (slave  -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface lcd_cmd_host_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       rb_cen;
    logic [5:0] rb_a;
    logic [7:0] rb_q;

    modport master (output cmd, cmd_valid, rb_cen, rb_a,
                    input  busy, done, rb_q);
    modport slave  (input  cmd, cmd_valid, rb_cen, rb_a,
                    output busy, done, rb_q);
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_cmd_fifo
//  Description : DEPTH x 4-bit command FIFO, synchronous push/pop,
//                asynchronous active-low reset.
//    clk, reset      clock / async active-low reset
//    push, wdata     write request and data (ignored while full)
//    pop             read request (ignored while empty)
//    head            entry at the read pointer (show-ahead)
//    count           registered occupancy
//    full, empty     registered flags, consistent with count
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_cmd_fifo #(
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   push,
    input  wire logic [3:0]             wdata,
    input  wire logic                   pop,
    output logic      [3:0]             head,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    assign w_push      = push & ~r_full;
    assign w_pop       = pop & ~r_empty;
    assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage needs no reset: clearing the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_host.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_cmd_host
//  Description : Host driver for LCD_CTRL. Buffers a command script, issues
//                one command per LCD_CTRL idle window, and after a Write
//                completes reads the IRB image back and streams it out.
//    clk, reset         clock / async active-low reset
//    ld_cmd, ld_valid   script load port; ld_ready = FIFO not full
//    start              1-cycle pulse, honoured only in IDLE
//    lcd                LCD_CTRL / IRB bus (master modport)
//    pix_data/valid/last  readback pixel stream, no backpressure
//    finished           sticky, set after readback, cleared by start
//    err_to             sticky busy-rise timeout, cleared by start
//    cksum, cksum_valid only when LCD_HOST_CKSUM_EN is defined: 16-bit
//                       wrapping pixel sum, pulsed with pix_last
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_cmd_host
    import lcd_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int IMG_N   = lcd_pkg::IMG_N,
    parameter int BUSY_TO = 255
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [3:0]  ld_cmd,
    input  wire logic        ld_valid,
    output logic             ld_ready,
    input  wire logic        start,
    lcd_cmd_host_if.master   lcd,
    output logic      [7:0]  pix_data,
    output logic             pix_valid,
    output logic             pix_last,
    output logic             finished,
    output logic             err_to
`ifdef LCD_HOST_CKSUM_EN
    ,
    output logic      [15:0] cksum,
    output logic             cksum_valid
`endif
);
    localparam int TW = $clog2(BUSY_TO + 1);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] C_TO_LAST   = TW'(BUSY_TO - 1);
    localparam logic [5:0]    C_LAST_ADDR = 6'(IMG_N - 1);

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cmd, w_cmd_nxt;
    logic          r_cmd_valid, w_cmd_valid_nxt;
    logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
    logic          r_rb_cen, w_rb_cen_nxt;
    logic [5:0]    r_rb_a, w_rb_a_nxt;
    logic          r_finished, w_finished_nxt;
    logic          r_err_to, w_err_to_nxt;
    logic          w_pop;
    logic          w_rd_entry;

    // Readback pipeline: r_q_vld marks the cycle in which rb_q holds data
    // for an address presented the cycle before.
    logic          r_q_vld;
    logic          r_q_last;
    logic [7:0]    r_pix_data;
    logic          r_pix_valid;
    logic          r_pix_last;

    logic [3:0]    w_fifo_head;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_push;

    assign w_push = ld_valid & ~w_fifo_full;

    lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (ld_cmd),
        .pop   (w_pop),
        .head  (w_fifo_head),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Derived from the registered count, so a same-cycle pop does not
    // reopen the load port until the following cycle.
    assign ld_ready = (w_fifo_count != C_DEPTH_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 4'h0;
            r_cmd_valid <= 1'b0;
            r_to_cnt    <= '0;
            r_rb_cen    <= 1'b1;
            r_rb_a      <= 6'd0;
            r_finished  <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_rb_cen    <= w_rb_cen_nxt;
            r_rb_a      <= w_rb_a_nxt;
            r_finished  <= w_finished_nxt;
            r_err_to    <= w_err_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_cmd_valid_nxt = 1'b0;
        w_to_cnt_nxt    = r_to_cnt;
        w_rb_cen_nxt    = r_rb_cen;
        w_rb_a_nxt      = r_rb_a;
        w_finished_nxt  = r_finished;
        w_err_to_nxt    = r_err_to;
        w_pop           = 1'b0;
        w_rd_entry      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_ISSUE;
                    w_finished_nxt = 1'b0;
                    w_err_to_nxt   = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (w_fifo_empty) begin
                    w_state_nxt    = ST_IDLE;
                    w_finished_nxt = 1'b0;
                end else if (!lcd.busy) begin
                    w_pop           = 1'b1;
                    w_cmd_nxt       = w_fifo_head;
                    w_cmd_valid_nxt = 1'b1;
                    w_to_cnt_nxt    = '0;
                    w_state_nxt     = ST_ACK;
                end
            end
            ST_ACK: begin
                if (lcd.busy) begin
                    w_state_nxt = ST_EXEC;
                end else if (r_to_cnt == C_TO_LAST) begin
                    // Give up on this command and move to the next one.
                    w_err_to_nxt = 1'b1;
                    w_state_nxt  = ST_ISSUE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TW'(1);
                end
            end
            ST_EXEC: begin
                if (!lcd.busy) begin
                    w_state_nxt = (r_cmd == CMD_WRITE) ? ST_WAIT_DONE : ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (lcd.done) begin
                    w_state_nxt  = ST_RD;
                    w_rb_cen_nxt = 1'b0;
                    w_rb_a_nxt   = 6'd0;
                    w_rd_entry   = 1'b1;
                end
            end
            ST_RD: begin
                if (r_rb_a == C_LAST_ADDR) begin
                    w_rb_cen_nxt = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                end else begin
                    w_rb_a_nxt = r_rb_a + 6'd1;
                end
            end
            ST_DRAIN: begin
                // The last IRB word arrives this cycle; it leaves with pix_last.
                w_finished_nxt = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_vld     <= 1'b0;
            r_q_last    <= 1'b0;
            r_pix_data  <= 8'h00;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
        end else begin
            r_q_vld     <= ~r_rb_cen;
            r_q_last    <= ~r_rb_cen & (r_rb_a == C_LAST_ADDR);
            if (r_q_vld) r_pix_data <= lcd.rb_q;
            r_pix_valid <= r_q_vld;
            r_pix_last  <= r_q_vld & r_q_last;
        end
    end

`ifdef LCD_HOST_CKSUM_EN
    logic [15:0] r_cksum;
    logic        r_cksum_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cksum       <= 16'h0000;
            r_cksum_valid <= 1'b0;
        end else begin
            if (w_rd_entry)   r_cksum <= 16'h0000;
            else if (r_q_vld) r_cksum <= r_cksum + {8'h00, lcd.rb_q};
            r_cksum_valid <= r_q_vld & r_q_last;
        end
    end

    assign cksum       = r_cksum;
    assign cksum_valid = r_cksum_valid;
`endif

    assign lcd.cmd       = r_cmd;
    assign lcd.cmd_valid = r_cmd_valid;
    assign lcd.rb_cen    = r_rb_cen;
    assign lcd.rb_a      = r_rb_a;
    assign pix_data      = r_pix_data;
    assign pix_valid     = r_pix_valid;
    assign pix_last      = r_pix_last;
    assign finished      = r_finished;
    assign err_to        = r_err_to;

endmodule
`default_nettype wire
